// File: rtl/eth_axis_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : eth_axis_tx_framer
// Summary  : Ethernet TX framer. Serialises a 14-byte header, then the
//            payload, as one 8-bit AXI-Stream frame. Optional 802.1Q tag
//            insertion is enabled with the macro ETH_TX_FRAMER_VLAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eth_axis_tx_framer #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int CNT_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic        logic_clk,
    input  logic        logic_rst_n,
    input  logic        s_hdr_valid,
    output logic        s_hdr_ready,
    input  logic [47:0] s_hdr_dest_mac,
    input  logic [47:0] s_hdr_src_mac,
    input  logic [15:0] s_hdr_type,
`ifdef ETH_TX_FRAMER_VLAN_EN
    input  logic        s_hdr_vlan_valid,
    input  logic [15:0] s_hdr_vlan_tci,
`endif
    input  logic [7:0]  s_payload_tdata,
    input  logic        s_payload_tvalid,
    output logic        s_payload_tready,
    input  logic        s_payload_tlast,
    input  logic        s_payload_tuser,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    output logic        busy,
    output logic        error_oversize
);

`ifdef ETH_TX_FRAMER_VLAN_EN
    localparam int HDR_BYTES = 18;
`else
    localparam int HDR_BYTES = 14;
`endif
    localparam int HDR_W = HDR_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [HDR_W-1:0]   hdr_sr_q, hdr_sr_d;
    logic [4:0]         hdr_cnt_q, hdr_cnt_d;
    logic [4:0]         hdr_last_q, hdr_last_d;
    logic [CNT_W-1:0]   pay_cnt_q, pay_cnt_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic               err_q, err_d;
    logic               hdr_en_q;

    logic [HDR_W-1:0]   hdr_full;
    logic [4:0]         hdr_last;
    logic               out_load;

`ifdef ETH_TX_FRAMER_VLAN_EN
    always_comb begin
        if (s_hdr_vlan_valid) begin
            hdr_full = {s_hdr_dest_mac, s_hdr_src_mac, 8'h81, 8'h00, s_hdr_vlan_tci, s_hdr_type};
            hdr_last = 5'd17;
        end else begin
            hdr_full = {s_hdr_dest_mac, s_hdr_src_mac, s_hdr_type, 32'h0};
            hdr_last = 5'd13;
        end
    end
`else
    always_comb begin
        hdr_full = {s_hdr_dest_mac, s_hdr_src_mac, s_hdr_type};
        hdr_last = 5'd13;
    end
`endif

    // Output register may take a new byte whenever it is empty or being drained.
    assign out_load = !tvalid_q || tx_axis_tready;

    always_comb begin
        state_d          = state_q;
        hdr_sr_d         = hdr_sr_q;
        hdr_cnt_d        = hdr_cnt_q;
        hdr_last_d       = hdr_last_q;
        pay_cnt_d        = pay_cnt_q;
        tdata_d          = tdata_q;
        tvalid_d         = out_load ? 1'b0 : tvalid_q;
        tlast_d          = tlast_q;
        tuser_d          = tuser_q;
        err_d            = 1'b0;
        s_hdr_ready      = (state_q == ST_IDLE) && hdr_en_q;
        s_payload_tready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_hdr_valid && hdr_en_q) begin
                    hdr_sr_d   = hdr_full;
                    hdr_cnt_d  = 5'd0;
                    hdr_last_d = hdr_last;
                    pay_cnt_d  = '0;
                    state_d    = ST_HEADER;
                    // First header byte goes straight out so it appears the cycle after accept.
                    if (out_load) begin
                        tdata_d   = hdr_full[HDR_W-1 -: 8];
                        tvalid_d  = 1'b1;
                        tlast_d   = 1'b0;
                        tuser_d   = 1'b0;
                        hdr_sr_d  = hdr_full << 8;
                        hdr_cnt_d = 5'd1;
                    end
                end
            end
            ST_HEADER: begin
                if (out_load) begin
                    tdata_d   = hdr_sr_q[HDR_W-1 -: 8];
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    tuser_d   = 1'b0;
                    hdr_sr_d  = hdr_sr_q << 8;
                    hdr_cnt_d = hdr_cnt_q + 5'd1;
                    if (hdr_cnt_q == hdr_last_q) begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                s_payload_tready = out_load;
                if (s_payload_tvalid && out_load) begin
                    tdata_d   = s_payload_tdata;
                    tvalid_d  = 1'b1;
                    pay_cnt_d = pay_cnt_q + CNT_W'(1);
                    if (s_payload_tlast) begin
                        tlast_d = 1'b1;
                        tuser_d = s_payload_tuser;
                        state_d = ST_IDLE;
                    end else if (pay_cnt_q == CNT_W'(MAX_PAYLOAD - 1)) begin
                        // Truncate: close the frame as bad and discard the rest.
                        tlast_d = 1'b1;
                        tuser_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        tlast_d = 1'b0;
                        tuser_d = 1'b0;
                    end
                end
            end
            ST_DROP: begin
                s_payload_tready = 1'b1;
                if (s_payload_tvalid && s_payload_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_q    <= ST_IDLE;
            hdr_sr_q   <= '0;
            hdr_cnt_q  <= '0;
            hdr_last_q <= '0;
            pay_cnt_q  <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            err_q      <= 1'b0;
            hdr_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_sr_q   <= hdr_sr_d;
            hdr_cnt_q  <= hdr_cnt_d;
            hdr_last_q <= hdr_last_d;
            pay_cnt_q  <= pay_cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            err_q      <= err_d;
            hdr_en_q   <= 1'b1;
        end
    end

    assign tx_axis_tdata  = tdata_q;
    assign tx_axis_tvalid = tvalid_q;
    assign tx_axis_tlast  = tlast_q;
    assign tx_axis_tuser  = tuser_q;
    assign busy           = (state_q != ST_IDLE);
    assign error_oversize = err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_axis_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_axis_tx_framer
// Summary  : Scoreboard bench for eth_axis_tx_framer (MAX_PAYLOAD = 46).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_axis_tx_framer;

    localparam int MAXP = 46;
    localparam int CW   = $clog2(MAXP + 1);

    logic        logic_clk;
    logic        logic_rst_n;
    logic        s_hdr_valid;
    logic        s_hdr_ready;
    logic [47:0] s_hdr_dest_mac;
    logic [47:0] s_hdr_src_mac;
    logic [15:0] s_hdr_type;
`ifdef ETH_TX_FRAMER_VLAN_EN
    logic        s_hdr_vlan_valid;
    logic [15:0] s_hdr_vlan_tci;
`endif
    logic [7:0]  s_payload_tdata;
    logic        s_payload_tvalid;
    logic        s_payload_tready;
    logic        s_payload_tlast;
    logic        s_payload_tuser;
    logic [7:0]  tx_axis_tdata;
    logic        tx_axis_tvalid;
    logic        tx_axis_tready;
    logic        tx_axis_tlast;
    logic        tx_axis_tuser;
    logic        busy;
    logic        error_oversize;

    eth_axis_tx_framer #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
        .logic_clk        (logic_clk),
        .logic_rst_n      (logic_rst_n),
        .s_hdr_valid      (s_hdr_valid),
        .s_hdr_ready      (s_hdr_ready),
        .s_hdr_dest_mac   (s_hdr_dest_mac),
        .s_hdr_src_mac    (s_hdr_src_mac),
        .s_hdr_type       (s_hdr_type),
`ifdef ETH_TX_FRAMER_VLAN_EN
        .s_hdr_vlan_valid (s_hdr_vlan_valid),
        .s_hdr_vlan_tci   (s_hdr_vlan_tci),
`endif
        .s_payload_tdata  (s_payload_tdata),
        .s_payload_tvalid (s_payload_tvalid),
        .s_payload_tready (s_payload_tready),
        .s_payload_tlast  (s_payload_tlast),
        .s_payload_tuser  (s_payload_tuser),
        .tx_axis_tdata    (tx_axis_tdata),
        .tx_axis_tvalid   (tx_axis_tvalid),
        .tx_axis_tready   (tx_axis_tready),
        .tx_axis_tlast    (tx_axis_tlast),
        .tx_axis_tuser    (tx_axis_tuser),
        .busy             (busy),
        .error_oversize   (error_oversize)
    );

    initial begin
        logic_clk = 1'b0;
        forever #5 logic_clk = ~logic_clk;
    end

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    frame_start = 0;
    int    frame_len_cyc = 0;
    bit    in_frame = 0;
    int    err_pulses = 0;
    bit    stall_pend = 0;
    beat_t stall_beat;
    bit    toggle_rdy = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Downstream ready: held high, or toggled every cycle for backpressure.
    initial begin
        tx_axis_tready = 1'b1;
        forever begin
            @(posedge logic_clk);
            #1;
            tx_axis_tready = toggle_rdy ? !tx_axis_tready : 1'b1;
        end
    end

    // Output monitor: handshakes pop the scoreboard; stalls must hold data.
    always @(negedge logic_clk) begin
        beat_t obs;
        beat_t e;
        cyc++;
        obs = '{data: tx_axis_tdata, last: tx_axis_tlast, user: tx_axis_tuser};
        if (error_oversize) err_pulses++;
        if (stall_pend) begin
            check_eq("stall_valid", 64'(tx_axis_tvalid), 64'd1);
            check_eq("stall_data", 64'(obs), 64'(stall_beat));
        end
        if (tx_axis_tvalid && tx_axis_tready) begin
            stall_pend = 0;
            if (exp_q.size() == 0) begin
                check_eq("extra_beat_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat", 64'(obs), 64'(e));
                if (!in_frame) begin
                    in_frame    = 1;
                    frame_start = cyc;
                end
                if (obs.last) begin
                    in_frame      = 0;
                    frame_len_cyc = cyc - frame_start + 1;
                end
            end
        end else if (tx_axis_tvalid) begin
            stall_pend = 1;
            stall_beat = obs;
        end else begin
            stall_pend = 0;
        end
    end

    task automatic step();
        @(posedge logic_clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] typ, input int len, input logic bad,
                              input logic [7:0] base, input bit vlan,
                              input logic [15:0] tci, input int abort_at);
        logic [143:0] h;
        int           nh;
        int           nout;
        bit           trunc;
        bit           acc;
        int           t;
        int           idx;
        if (vlan) begin
            h  = {dst, src, 8'h81, 8'h00, tci, typ};
            nh = 18;
        end else begin
            h  = {dst, src, typ, 32'h0};
            nh = 14;
        end
        for (int i = 0; i < nh; i++) begin
            exp_q.push_back('{data: h[143-8*i -: 8], last: 1'b0, user: 1'b0});
        end
        trunc = (len > MAXP);
        nout  = trunc ? MAXP : len;
        for (int i = 0; i < nout; i++) begin
            exp_q.push_back('{data: base + 8'(i), last: (i == nout - 1),
                              user: (i == nout - 1) && (trunc || bad)});
        end

        s_hdr_dest_mac = dst;
        s_hdr_src_mac  = src;
        s_hdr_type     = typ;
`ifdef ETH_TX_FRAMER_VLAN_EN
        s_hdr_vlan_valid = vlan;
        s_hdr_vlan_tci   = tci;
`endif
        s_hdr_valid = 1'b1;
        acc = 0;
        t   = 0;
        while (!acc && t < 200) begin
            @(negedge logic_clk);
            acc = s_hdr_ready;
            step();
            t++;
        end
        s_hdr_valid = 1'b0;
        check_eq("hdr_accept", 64'(acc), 64'd1);
        check_eq("hdr_ready_when_busy", 64'(s_hdr_ready), 64'd0);

        idx = 0;
        t   = 0;
        s_payload_tvalid = 1'b1;
        s_payload_tdata  = base;
        s_payload_tlast  = (len == 1);
        s_payload_tuser  = (len == 1) && bad;
        while (idx < len && t < 2000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                #2 logic_rst_n = 1'b0;
                #1;
                check_eq("rst_tvalid", 64'(tx_axis_tvalid), 64'd0);
                check_eq("rst_tlast", 64'(tx_axis_tlast), 64'd0);
                check_eq("rst_busy", 64'(busy), 64'd0);
                check_eq("rst_hdr_ready", 64'(s_hdr_ready), 64'd0);
                check_eq("rst_pay_ready", 64'(s_payload_tready), 64'd0);
                exp_q.delete();
                in_frame         = 0;
                s_payload_tvalid = 1'b0;
                s_payload_tlast  = 1'b0;
                s_payload_tuser  = 1'b0;
                step();
                step();
                logic_rst_n = 1'b1;
                #1;
                check_eq("post_rst_hdr_ready_low", 64'(s_hdr_ready), 64'd0);
                step();
                check_eq("post_rst_hdr_ready_high", 64'(s_hdr_ready), 64'd1);
                return;
            end
            @(negedge logic_clk);
            acc = s_payload_tready;
            step();
            t++;
            if (acc) begin
                idx++;
                if (idx < len) begin
                    s_payload_tdata = base + 8'(idx);
                    s_payload_tlast = (idx == len - 1);
                    s_payload_tuser = (idx == len - 1) && bad;
                end else begin
                    s_payload_tvalid = 1'b0;
                    s_payload_tlast  = 1'b0;
                    s_payload_tuser  = 1'b0;
                end
            end
        end
        check_eq("payload_consumed", 64'(idx), 64'(len));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            step();
            t++;
        end
        step();
        check_eq("drain_qsize", 64'(exp_q.size()), 64'd0);
    endtask

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC1  = 48'h0200_0000_0001;

    initial begin
        logic_rst_n      = 1'b0;
        s_hdr_valid      = 1'b0;
        s_hdr_dest_mac   = '0;
        s_hdr_src_mac    = '0;
        s_hdr_type       = '0;
`ifdef ETH_TX_FRAMER_VLAN_EN
        s_hdr_vlan_valid = 1'b0;
        s_hdr_vlan_tci   = '0;
`endif
        s_payload_tdata  = '0;
        s_payload_tvalid = 1'b0;
        s_payload_tlast  = 1'b0;
        s_payload_tuser  = 1'b0;

        #2;
        check_eq("reset_hdr_ready", 64'(s_hdr_ready), 64'd0);
        check_eq("reset_pay_ready", 64'(s_payload_tready), 64'd0);
        check_eq("reset_tx", 64'({tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser}), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_err", 64'(error_oversize), 64'd0);
        repeat (3) step();
        logic_rst_n = 1'b1;
        #1;
        check_eq("rel_hdr_ready_low", 64'(s_hdr_ready), 64'd0);
        step();
        check_eq("rel_hdr_ready_high", 64'(s_hdr_ready), 64'd1);

        // Payload presented before any header is held off.
        s_payload_tvalid = 1'b1;
        repeat (3) step();
        check_eq("early_payload_ready", 64'(s_payload_tready), 64'd0);
        check_eq("early_payload_tvalid", 64'(tx_axis_tvalid), 64'd0);
        s_payload_tvalid = 1'b0;

        // Basic 46-byte frame (exactly MAX_PAYLOAD, must not be truncated).
        send_frame(BCAST, SRC1, 16'h0800, 46, 1'b0, 8'h00, 1'b0, 16'h0, -1);
        wait_drain();
        check_eq("basic_frame_cycles", 64'(frame_len_cyc), 64'd60);
        check_eq("basic_idle_busy", 64'(busy), 64'd0);

        // Same frame under backpressure.
        toggle_rdy = 1;
        send_frame(BCAST, SRC1, 16'h0800, 46, 1'b0, 8'h00, 1'b0, 16'h0, -1);
        wait_drain();
        toggle_rdy = 0;
        step();

        // Bad payload flagged on tlast.
        send_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h86DD, 10, 1'b1, 8'h40, 1'b0, 16'h0, -1);
        wait_drain();

        // Oversize: 50 bytes against a 46-byte limit.
        err_pulses = 0;
        send_frame(48'hA1A2_A3A4_A5A6, SRC1, 16'h0806, 50, 1'b0, 8'h80, 1'b0, 16'h0, -1);
        wait_drain();
        check_eq("oversize_pulses", 64'(err_pulses), 64'd1);
        check_eq("oversize_idle", 64'(busy), 64'd0);
        send_frame(48'h1020_3040_5060, SRC1, 16'h0800, 20, 1'b0, 8'h10, 1'b0, 16'h0, -1);
        wait_drain();

        // Back-to-back frames, with a single-byte payload.
        send_frame(48'h0A0B_0C0D_0E0F, SRC1, 16'h1234, 1, 1'b0, 8'hC0, 1'b0, 16'h0, -1);
        send_frame(48'h0F0E_0D0C_0B0A, SRC1, 16'h5678, 3, 1'b1, 8'hD0, 1'b0, 16'h0, -1);
        wait_drain();

        // Reset during payload byte 5, then a clean frame.
        send_frame(BCAST, SRC1, 16'h0800, 30, 1'b0, 8'h20, 1'b0, 16'h0, 5);
        send_frame(48'h5A5A_5A5A_5A5A, SRC1, 16'h0800, 12, 1'b0, 8'h60, 1'b0, 16'h0, -1);
        wait_drain();

`ifdef ETH_TX_FRAMER_VLAN_EN
        send_frame(BCAST, SRC1, 16'h0800, 8, 1'b0, 8'h00, 1'b1, 16'h0064, -1);
        wait_drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
